// File: rtl/kv_store_wb.sv
// kv_store_wb: Wishbone-mapped key-value store with a fixed-latency sequential scan
module kv_store_wb #(
  parameter int          KEY_W     = 16,
  parameter int          VAL_W     = 32,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2;
  localparam logic [1:0] OP_PUT = 2'd0, OP_GET = 2'd1, OP_DEL = 2'd2, OP_CLEAR = 2'd3;
  logic [KEY_W-1:0] key_r;
  logic [VAL_W-1:0] val_in, val_out;
  logic [KEY_W-1:0] keys [DEPTH];
  logic [VAL_W-1:0] vals [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CW-1:0]    count;
  logic [1:0]       state, op;
  logic [IW-1:0]    idx, hit_idx, free_idx;
  logic             hit_f, free_f, hit, err, ovr, irq;
  logic             sel_blk, busy, wr, unused;
  logic [2:0]       reg_idx;
  logic [31:0]      status, rd_data;

  assign sel_blk = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign reg_idx = wbs_adr_i[4:2];
  assign busy    = state != IDLE;
  assign wr      = wbs_ack_o & sel_blk & wbs_we_i;
  assign status  = {{(16 - CW){1'b0}}, count, 12'd0, ovr, err, hit, busy};
  assign busy_o  = busy;
  assign irq_o   = irq;
  assign unused  = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Register read mux; unmapped and write-only words read as zero
  always_comb
    rd_data = reg_idx == 3'd0 ? 32'(key_r) :
              reg_idx == 3'd1 ? 32'(val_in) :
              reg_idx == 3'd3 ? status :
              reg_idx == 3'd4 ? 32'(val_out) : 32'd0;

  // Single-cycle ack with a mandatory low cycle after it; read data only alongside ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= sel_blk & ~wbs_ack_o;
      wbs_dat_o <= (sel_blk & ~wbs_ack_o & ~wbs_we_i) ? rd_data : '0;
    end

  // Register writes (taken in the ack cycle), command FSM and the entry store
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state    <= IDLE;
      op       <= OP_PUT;
      idx      <= '0;
      hit_idx  <= '0;
      free_idx <= '0;
      hit_f    <= 1'b0;
      free_f   <= 1'b0;
      hit      <= 1'b0;
      err      <= 1'b0;
      ovr      <= 1'b0;
      irq      <= 1'b0;
      key_r    <= '0;
      val_in   <= '0;
      val_out  <= '0;
      valid    <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        keys[i] <= '0;
        vals[i] <= '0;
      end
    end else begin
      irq <= 1'b0;
      if (wr && reg_idx <= 3'd2 && busy) ovr <= 1'b1;
      else if (wr) begin
        if (reg_idx == 3'd0) key_r <= KEY_W'(merge(32'(key_r), wbs_dat_i, wbs_sel_i));
        if (reg_idx == 3'd1) val_in <= VAL_W'(merge(32'(val_in), wbs_dat_i, wbs_sel_i));
        if (reg_idx == 3'd2 && wbs_sel_i[0]) begin
          op     <= wbs_dat_i[1:0];
          idx    <= '0;
          hit_f  <= 1'b0;
          free_f <= 1'b0;
          if (wbs_dat_i[1:0] == OP_CLEAR) begin
            valid <= '0;
            count <= '0;
            state <= COMMIT;
          end else state <= SCAN;
        end
        if (reg_idx == 3'd3 && wbs_sel_i[0]) begin
          if (wbs_dat_i[3]) ovr <= 1'b0;
          if (wbs_dat_i[2]) err <= 1'b0;
        end
      end
      if (state == SCAN) begin
        if (valid[idx] && keys[idx] == key_r) begin
          hit_f   <= 1'b1;
          hit_idx <= idx;
        end
        if (!valid[idx] && !free_f) begin
          free_f   <= 1'b1;
          free_idx <= idx;
        end
        if (idx == IW'(DEPTH - 1)) state <= COMMIT;
        else idx <= idx + 1'b1;
      end else if (state == COMMIT) begin
        state <= IDLE;
        irq   <= 1'b1;
        hit   <= hit_f & (op != OP_CLEAR);
        if (op == OP_PUT) begin
          if (hit_f) vals[hit_idx] <= val_in;
          else if (free_f) begin
            keys[free_idx]  <= key_r;
            vals[free_idx]  <= val_in;
            valid[free_idx] <= 1'b1;
            if (count != CW'(DEPTH)) count <= count + 1'b1;
          end else err <= 1'b1;
        end
        if (op == OP_GET && hit_f) val_out <= vals[hit_idx];
        if (op == OP_DEL && hit_f) begin
          valid[hit_idx] <= 1'b0;
          if (count != '0) count <= count - 1'b1;
        end
      end
    end
endmodule
